timing_state_generator: RTL

Cycle-state sequencer for the 6502 core. Produces the one-hot T-state vector that the decode AND-gate array combines with opcode bits. Advances one T-state per enabled processor cycle. Returns to opcode fetch when the decode array reports end-of-instruction, and latches the reset and interrupt sequence flags that decode uses to force the BRK-style vector sequence.

---
 rtl/cpu_timing_pkg.sv | 35 +++
 rtl/timing_state_generator_onehot_to_index.sv | 16 +
 rtl/timing_state_generator.sv | 73 +++++++
 3 files changed

// File: rtl/cpu_timing_pkg.sv
// Shared T-state definitions for the timing generator and the decode stages.
// Pure declarations: no latency, no flow control.
package cpu_timing_pkg;

  localparam int TSTATE_WIDTH      = 7;
  localparam int CYCLE_INDEX_WIDTH = 3;

  typedef enum logic [TSTATE_WIDTH-1:0] {
    T0_STATE = 7'b0000001,
    T1_STATE = 7'b0000010,
    T2_STATE = 7'b0000100,
    T3_STATE = 7'b0001000,
    T4_STATE = 7'b0010000,
    T5_STATE = 7'b0100000,
    T6_STATE = 7'b1000000
  } tstate_e;

  localparam tstate_e RESET_STATE = T0_STATE;

  // Explicit successor table, so the state register can only ever hold a named one-hot value.
  function automatic tstate_e tstate_succ(input tstate_e cur);
    tstate_e nxt;
    case (cur)
      T0_STATE: nxt = T1_STATE;
      T1_STATE: nxt = T2_STATE;
      T2_STATE: nxt = T3_STATE;
      T3_STATE: nxt = T4_STATE;
      T4_STATE: nxt = T5_STATE;
      T5_STATE: nxt = T6_STATE;
      default:  nxt = T0_STATE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/timing_state_generator_onehot_to_index.sv
// One-hot T-state to binary index encoder; purely combinational, no flow control.
module onehot_to_index
  import cpu_timing_pkg::*;
(
  input  logic [TSTATE_WIDTH-1:0]      onehot,
  output logic [CYCLE_INDEX_WIDTH-1:0] index
);

  always_comb begin
    index = '0;
    for (int k = 0; k < TSTATE_WIDTH; k++) begin
      if (onehot[k]) index = index | CYCLE_INDEX_WIDTH'(k);
    end
  end

endmodule

// File: rtl/timing_state_generator.sv
// 6502 T-state sequencer with reset/interrupt sequence flags; outputs registered, new state visible
// the cycle after an advance edge. Stalls (holds everything) unless ClockEnable & (Ready | WriteCycle).
module timing_state_generator
  import cpu_timing_pkg::*;
#(
  parameter int MaxCycle = 6
) (
  input  logic                         GlobalClock,
  input  logic                         Reset,
  input  logic                         ClockEnable,
  input  logic                         Ready,
  input  logic                         WriteCycle,
  input  logic                         EndInstr,
  input  logic                         IrqPending,
  input  logic                         NmiPending,
  output logic [TSTATE_WIDTH-1:0]      Tstate,
  output logic [CYCLE_INDEX_WIDTH-1:0] CycleIndex,
  output logic                         Sync,
  output logic                         ResetCycle,
  output logic                         InterruptCycle,
  output logic                         NmiAck,
  output logic                         Timeout
);

  localparam logic [TSTATE_WIDTH-1:0] MAX_STATE = TSTATE_WIDTH'(1) << MaxCycle;

  tstate_e state_q;
  logic    adv;
  logic    at_max;
  logic    enter_t0;

  // Writes cannot be stretched by RDY, so a write cycle always advances on its tick.
  assign adv      = ClockEnable & (Ready | WriteCycle);
  assign at_max   = (state_q == MAX_STATE);
  assign enter_t0 = adv & (state_q != T0_STATE) & (EndInstr | at_max);

  always_ff @(posedge GlobalClock) begin
    if (Reset) begin
      state_q        <= RESET_STATE;
      ResetCycle     <= 1'b1;
      InterruptCycle <= 1'b0;
      NmiAck         <= 1'b0;
      Timeout        <= 1'b0;
    end else begin
      NmiAck <= 1'b0;
      if (adv) begin
        state_q <= enter_t0 ? T0_STATE : tstate_succ(state_q);
        if (at_max && !EndInstr) Timeout <= 1'b1;
        // Sequence flags change only when a new instruction starts, so they hold across it.
        if (enter_t0) begin
          ResetCycle <= 1'b0;
          if (ResetCycle) begin
            InterruptCycle <= 1'b0;
          end else if (NmiPending) begin
            InterruptCycle <= 1'b1;
            NmiAck         <= 1'b1;
          end else begin
            InterruptCycle <= IrqPending;
          end
        end
      end
    end
  end

  assign Tstate = state_q;
  assign Sync   = state_q[0];

  onehot_to_index u_index (
    .onehot (state_q),
    .index  (CycleIndex)
  );

endmodule
